// File: rtl/mascota_needs_fsm.sv
// Pet needs state machine with saturating need levels, tick decay, A/B/C buttons and modes.
// Define MASCOTA_AUTOSLEEP_EN to force SLEEP when energy decays below the low threshold.
module mascota_needs_fsm #(
    parameter int unsigned NUM_NEEDS = 5,
    parameter int unsigned LVL_W     = 4,
    parameter int unsigned TICK_BASE = 50000000,
    parameter int unsigned REFILL    = 4,
    parameter int unsigned LOW_TH    = 3,
    localparam int unsigned SEL_W    = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       A,
    input  logic                       B,
    input  logic                       C,
    input  logic                       test,
    input  logic [1:0]                 time_control,
    output logic [NUM_NEEDS*LVL_W-1:0] levels,
    output logic [SEL_W-1:0]           sel,
    output logic [LVL_W-1:0]           sel_level,
    output logic [2:0]                 state,
    output logic [2:0]                 mood,
    output logic                       tick
);

    typedef enum logic [2:0] {
        StNormal = 3'd0,
        StSleep  = 3'd1,
        StTest   = 3'd2,
        StDead   = 3'd3
    } state_e;

    localparam logic [LVL_W-1:0] MaxLvl   = {LVL_W{1'b1}};
    localparam logic [LVL_W:0]   Refill   = (LVL_W + 1)'(REFILL);
    localparam logic [LVL_W:0]   LowTh    = (LVL_W + 1)'(LOW_TH);
    localparam logic [LVL_W:0]   OneLvl   = (LVL_W + 1)'(1);
    localparam logic [31:0]      TickBase = 32'(TICK_BASE);
    localparam logic [SEL_W-1:0] LastSel  = SEL_W'(NUM_NEEDS - 1);

    function automatic logic [LVL_W-1:0] sat_add(input logic [LVL_W-1:0] a,
                                                 input logic [LVL_W:0]   b);
        logic [LVL_W+1:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > {2'b00, MaxLvl}) ? MaxLvl : s[LVL_W-1:0];
    endfunction

    function automatic logic [LVL_W-1:0] sat_dec(input logic [LVL_W-1:0] a);
        return (a == '0) ? '0 : a - LVL_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic [LVL_W-1:0] lvl_q [NUM_NEEDS];
    logic [LVL_W-1:0] lvl_d [NUM_NEEDS];
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             parity_q, parity_d;
    logic [2:0]       mood_q, mood_d;
    logic [31:0]      cnt_q, cnt_d, thr;
    logic             tick_q, tick_d;
    logic             a_q, b_q, c_q;
    logic             a_rise, b_rise, c_rise;
    logic             alive, run, active;
    logic             any_zero, all_ok;
    logic [LVL_W-1:0] health_nxt;
    logic             mood_zero, mood_low;

    assign a_rise = A & ~a_q;
    assign b_rise = B & ~b_q;
    assign c_rise = C & ~c_q;
    assign alive  = (lvl_q[0] != '0);

    // Prescaler only runs while the pet is live and not under test.
    always_comb begin
        thr    = (TickBase >> time_control) - 32'd1;
        run    = ((state_q == StNormal) || (state_q == StSleep)) && alive && !test;
        cnt_d  = '0;
        tick_d = 1'b0;
        if (run) begin
            if (cnt_q >= thr) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // Health trend from the pre-tick levels of the other needs.
    always_comb begin
        any_zero = 1'b0;
        all_ok   = 1'b1;
        for (int i = 1; i < NUM_NEEDS; i++) begin
            if (lvl_q[i] == '0) any_zero = 1'b1;
            if ({1'b0, lvl_q[i]} < LowTh) all_ok = 1'b0;
        end
        if (any_zero) begin
            health_nxt = sat_dec(lvl_q[0]);
        end else if (all_ok) begin
            health_nxt = sat_add(lvl_q[0], OneLvl);
        end else begin
            health_nxt = lvl_q[0];
        end
    end

    always_comb begin
        lvl_d    = lvl_q;
        sel_d    = sel_q;
        state_d  = state_q;
        parity_d = parity_q;
        active   = (state_q == StTest) ||
                   (((state_q == StNormal) || (state_q == StSleep)) && alive);

        case (state_q)
            StNormal: begin
                if (!alive) begin
                    state_d = StDead;
                end else begin
                    if (tick_q) begin
                        lvl_d[0] = health_nxt;
                        for (int i = 1; i < NUM_NEEDS; i++) lvl_d[i] = sat_dec(lvl_q[i]);
                    end
                    // A refill replaces the decay of the same channel.
                    for (int i = 0; i < NUM_NEEDS; i++) begin
                        if (b_rise && (sel_q == SEL_W'(i))) lvl_d[i] = sat_add(lvl_q[i], Refill);
                    end
                    if (c_rise) begin
                        state_d  = StSleep;
                        parity_d = 1'b0;
                    end
`ifdef MASCOTA_AUTOSLEEP_EN
                    if (tick_q && ({1'b0, lvl_d[1]} < LowTh)) begin
                        state_d  = StSleep;
                        parity_d = 1'b0;
                    end
`endif
                end
            end
            StSleep: begin
                if (!alive) begin
                    state_d = StDead;
                end else begin
                    if (tick_q) begin
                        lvl_d[0] = health_nxt;
                        lvl_d[1] = sat_add(lvl_q[1], OneLvl);
                        parity_d = ~parity_q;
                        if (parity_q) begin
                            for (int i = 2; i < NUM_NEEDS; i++) lvl_d[i] = sat_dec(lvl_q[i]);
                        end
                    end
                    if (c_rise || (tick_q && (lvl_d[1] == MaxLvl))) state_d = StNormal;
                end
            end
            StTest: begin
                for (int i = 0; i < NUM_NEEDS; i++) begin
                    if (sel_q == SEL_W'(i)) begin
                        if (b_rise) lvl_d[i] = sat_add(lvl_d[i], OneLvl);
                        if (c_rise) lvl_d[i] = sat_dec(lvl_d[i]);
                    end
                end
                if (!test) state_d = alive ? StNormal : StDead;
            end
            StDead: ;
            default: state_d = StNormal;
        endcase

        if (test) state_d = StTest;
        if (a_rise && active) sel_d = (sel_q == LastSel) ? '0 : sel_q + SEL_W'(1);
    end

    // Mood tracks the next state so it changes together with state and levels.
    always_comb begin
        mood_zero = 1'b0;
        mood_low  = 1'b0;
        for (int i = 0; i < NUM_NEEDS; i++) begin
            if (lvl_d[i] == '0) mood_zero = 1'b1;
            if ({1'b0, lvl_d[i]} < LowTh) mood_low = 1'b1;
        end
        if (state_d == StDead) begin
            mood_d = 3'd7;
        end else if (state_d == StTest) begin
            mood_d = 3'd5;
        end else if (state_d == StSleep) begin
            mood_d = 3'd4;
        end else if (mood_zero) begin
            mood_d = 3'd2;
        end else if (mood_low) begin
            mood_d = 3'd1;
        end else begin
            mood_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StNormal;
            lvl_q    <= '{default: MaxLvl};
            sel_q    <= '0;
            parity_q <= 1'b0;
            mood_q   <= 3'd0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            sel_q    <= sel_d;
            parity_q <= parity_d;
            mood_q   <= mood_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            a_q      <= A;
            b_q      <= B;
            c_q      <= C;
        end
    end

    always_comb begin
        levels    = '0;
        sel_level = '0;
        for (int i = 0; i < NUM_NEEDS; i++) begin
            levels[i*LVL_W +: LVL_W] = lvl_q[i];
            if (sel_q == SEL_W'(i)) sel_level = lvl_q[i];
        end
    end

    assign sel   = sel_q;
    assign state = state_q;
    assign mood  = mood_q;
    assign tick  = tick_q;

endmodule
